// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//   Parametrised serial pattern detector with a registered match pulse.
//   Watches a serial bit stream for an N-bit pattern (first bit received is
//   pattern[N-1]). The pattern can be reloaded at run time; overlapping or
//   restart-after-match behaviour is chosen by OVERLAP.
//
// Ports
//   Clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   en          in   sample In on this edge when high
//   In          in   serial data bit
//   load        in   load pattern_in as the active pattern (wins over en)
//   pattern_in  in   new pattern, same bit order as PATTERN
//   clr_cnt     in   synchronous clear of match_cnt (wins over a hit)
//   Out         out  one-cycle match pulse, high the cycle after the hit edge
//   progress    out  longest matched pattern prefix held in history, 0..N-1
//   match_cnt   out  saturating count of matches
// ---------------------------------------------------------------------------
module seq_detect_param #(
    parameter int          N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b0101,
    parameter bit          OVERLAP = 1'b1,
    parameter int          CNT_W   = 8
) (
    input  logic                   Clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   In,
    input  logic                   load,
    input  logic [N-1:0]           pattern_in,
    input  logic                   clr_cnt,
    output logic                   Out,
    output logic [$clog2(N)-1:0]   progress,
    output logic [CNT_W-1:0]       match_cnt
);

    localparam int             PW       = $clog2(N);
    localparam logic [PW-1:0]  FILL_MAX = PW'(N - 1);

    logic [N-1:0]  pat;
    logic [N-2:0]  hist;     // hist[0] is the newest bit
    logic [PW-1:0] fill;     // number of valid bits in hist

    logic [N-1:0]  cand;
    logic          sample;
    logic          hit;
    logic          pfx_ok;

    assign cand   = {hist, In};
    assign sample = en & ~load;
    assign hit    = sample && (fill == FILL_MAX) && (cand == pat);

    // Longest k with hist[k-1:0] == pat[N-1:N-k], limited to k <= fill.
    always_comb begin
        progress = '0;
        pfx_ok   = 1'b0;
        for (int unsigned k = 1; k < N; k++) begin
            pfx_ok = (k <= 32'(fill));
            for (int unsigned j = 0; j < k; j++) begin
                if (hist[j] != pat[N-k+j]) begin
                    pfx_ok = 1'b0;
                end
            end
            if (pfx_ok) begin
                progress = PW'(k);
            end
        end
    end

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            pat       <= PATTERN;
            hist      <= '0;
            fill      <= '0;
            Out       <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (load) begin
                pat  <= pattern_in;
                hist <= '0;
                fill <= '0;
                Out  <= 1'b0;
            end else if (en) begin
                Out <= hit;
                if (hit && !OVERLAP) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= cand[N-2:0];
                    if (fill != FILL_MAX) begin
                        fill <= fill + PW'(1);
                    end
                end
            end else begin
                Out <= 1'b0;
            end

            if (clr_cnt) begin
                match_cnt <= '0;
            end else if (hit && (match_cnt != '1)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    logic       Clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       In;
    logic       load;
    logic [3:0] pattern_in;
    logic       clr_cnt;

    logic       out_d, out_n, out_c;
    logic [1:0] prog_d, prog_n, prog_c;
    logic [7:0] cnt_d, cnt_n;
    logic [1:0] cnt_c;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    seq_detect_param #(.N(4), .PATTERN(4'b0101), .OVERLAP(1'b1), .CNT_W(8)) u_def (
        .Clk(Clk), .rst_n(rst_n), .en(en), .In(In), .load(load),
        .pattern_in(pattern_in), .clr_cnt(clr_cnt),
        .Out(out_d), .progress(prog_d), .match_cnt(cnt_d)
    );

    seq_detect_param #(.N(4), .PATTERN(4'b0101), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
        .Clk(Clk), .rst_n(rst_n), .en(en), .In(In), .load(load),
        .pattern_in(pattern_in), .clr_cnt(clr_cnt),
        .Out(out_n), .progress(prog_n), .match_cnt(cnt_n)
    );

    seq_detect_param #(.N(4), .PATTERN(4'b0101), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
        .Clk(Clk), .rst_n(rst_n), .en(en), .In(In), .load(load),
        .pattern_in(pattern_in), .clr_cnt(clr_cnt),
        .Out(out_c), .progress(prog_c), .match_cnt(cnt_c)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic clr = 1'b0);
        @(negedge Clk);
        en = 1'b1; In = b; load = 1'b0; clr_cnt = clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge Clk);
        en = 1'b0; In = 1'b1; load = 1'b0; clr_cnt = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] p);
        @(negedge Clk);
        en = 1'b1; In = 1'b1; load = 1'b1; pattern_in = p; clr_cnt = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        en = 1'b0; load = 1'b0; clr_cnt = 1'b0;
        rst_n = 1'b0;
        @(negedge Clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] s6;
        logic [5:0] e6d;
        logic [5:0] e6n;
        logic [4:0] e5;

        rst_n = 1'b0; en = 1'b0; In = 1'b0; load = 1'b0;
        pattern_in = 4'b0000; clr_cnt = 1'b0;
        #12;
        check("rst_out",  int'(out_d),  0);
        check("rst_prog", int'(prog_d), 0);
        check("rst_cnt",  int'(cnt_d),  0);
        @(negedge Clk);
        rst_n = 1'b1;

        // 0,1,0,1,0,1 : overlap hits after bits 4 and 6, non-overlap after 4 only
        s6  = 6'b010101;   // bit 5 sent first
        e6d = 6'b000101;
        e6n = 6'b000100;
        for (int i = 5; i >= 0; i--) begin
            send_bit(s6[i]);
            check($sformatf("ov_out_b%0d", 6 - i), int'(out_d), int'(e6d[i]));
            check($sformatf("nov_out_b%0d", 6 - i), int'(out_n), int'(e6n[i]));
            if (i == 5) check("ov_prog_b1", int'(prog_d), 1);
            if (i == 4) check("ov_prog_b2", int'(prog_d), 2);
            if (i == 3) check("ov_prog_b3", int'(prog_d), 3);
            if (i == 2) begin
                check("ov_prog_b4", int'(prog_d), 2);
                check("nov_prog_restart", int'(prog_n), 0);
            end
        end
        check("ov_cnt_6",  int'(cnt_d),  2);
        check("nov_cnt_6", int'(cnt_n),  1);
        check("nov_prog_6", int'(prog_n), 2);

        // six more bits: total overlap hits 5, CNT_W=2 saturates at 3
        for (int r = 0; r < 3; r++) begin
            send_bit(1'b0);
            send_bit(1'b1);
        end
        check("ov_cnt_12",  int'(cnt_d), 5);
        check("sat_cnt_12", int'(cnt_c), 3);
        check("nov_cnt_12", int'(cnt_n), 3);

        // clear on a hit edge: clear wins
        send_bit(1'b0);
        send_bit(1'b1, 1'b1);
        check("clr_hit_out", int'(out_d), 1);
        check("clr_hit_cnt", int'(cnt_d), 0);
        check("clr_sat_cnt", int'(cnt_c), 0);
        check("clr_nov_cnt", int'(cnt_n), 0);

        // en dropped between bits: single hit, one-cycle pulse
        pulse_reset();
        s6 = 6'b000101;
        for (int i = 3; i >= 0; i--) begin
            send_bit(s6[i]);
            check($sformatf("gap_out_b%0d", 4 - i), int'(out_d), (i == 0) ? 1 : 0);
            idle_cycle();
            check($sformatf("gap_idle_b%0d", 4 - i), int'(out_d), 0);
            if (i == 3) check("gap_prog_hold", int'(prog_d), 1);
        end
        check("gap_cnt", int'(cnt_d), 1);

        // reset mid-stream after 0,1,0
        pulse_reset();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("mid_prog_pre", int'(prog_d), 3);
        @(negedge Clk);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_prog_async", int'(prog_d), 0);
        check("mid_cnt_async",  int'(cnt_d),  0);
        @(negedge Clk);
        rst_n = 1'b1;
        e5 = 5'b00001;
        s6 = 6'b010101;   // bits 4..0 = 1,0,1,0,1
        for (int i = 4; i >= 0; i--) begin
            send_bit(s6[i]);
            check($sformatf("mid_out_b%0d", 5 - i), int'(out_d), int'(e5[i]));
        end

        // reload pattern mid-stream (In=1 on the load edge is ignored)
        send_bit(1'b0);
        send_bit(1'b1);
        check("pre_load_cnt", int'(cnt_d), 2);
        do_load(4'b1100);
        check("load_out",  int'(out_d),  0);
        check("load_prog", int'(prog_d), 0);
        check("load_cnt",  int'(cnt_d),  2);
        s6 = 6'b001100;
        for (int i = 3; i >= 0; i--) begin
            send_bit(s6[i]);
            check($sformatf("ld_out_b%0d", 4 - i), int'(out_d), (i == 0) ? 1 : 0);
            if (i == 3) check("ld_prog_b1", int'(prog_d), 1);
            if (i == 2) check("ld_prog_b2", int'(prog_d), 2);
            if (i == 1) check("ld_prog_b3", int'(prog_d), 3);
        end
        check("ld_cnt", int'(cnt_d), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
